// File: rtl/cpu_types_pkg.sv
// Shared processor types.
//   ramstate_t  : status reported by the RAM model each cycle
//   arb_state_t : grant state of the instruction/data memory arbiter
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single RAM port between instruction fetch and
// data load/store. Data has priority, but an instruction fetch that is
// pending is granted once MAX_DSTREAK data accesses have completed in a row.
// Ports:
//   CLK, nRST                 clock (rising edge), async active-low reset
//   iREN, iaddr               instruction read request and address
//   iwait, iload              instruction not yet served, fetched word
//   dREN, dWEN, daddr, dstore data read/write request, address, store data
//   dwait, dload              data access not yet served, loaded word
//   ramREN, ramWEN            RAM read/write strobes
//   ramaddr, ramstore         RAM address and write data
//   ramload, ramstate         RAM read data and status
//   memerr                    sticky: RAM reported ERROR since reset
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_DSTREAK = 4
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  ramstate_t         ramstate,
  output logic              memerr
);

  localparam int DS_W = $clog2(MAX_DSTREAK + 1);
  localparam logic [DS_W-1:0] DS_MAX = DS_W'(MAX_DSTREAK);

  arb_state_t      state_r;
  arb_state_t      next_s;
  logic [DS_W-1:0] dstreak_r;
  logic            memerr_r;
  logic            dreq_s;
  logic            icomp_s;
  logic            dcomp_s;

  assign dreq_s  = dREN | dWEN;
  // A completion needs the grant, the request still present, and ACCESS.
  assign icomp_s = (state_r == IGNT) && iREN   && (ramstate == ACCESS);
  assign dcomp_s = (state_r == DGNT) && dreq_s && (ramstate == ACCESS);

  assign iload  = ramload;
  assign dload  = ramload;
  assign memerr = memerr_r;

  // State register, data-streak counter and sticky error flag.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_r   <= IDLE;
      dstreak_r <= '0;
      memerr_r  <= 1'b0;
    end else begin
      state_r <= next_s;
      if ((state_r != IDLE) && (ramstate == ERROR)) begin
        memerr_r <= 1'b1;
      end
      // The streak only grows while a fetch is actually waiting behind data.
      if (dcomp_s && iREN) begin
        if (dstreak_r != DS_MAX) begin
          dstreak_r <= dstreak_r + DS_W'(1);
        end
      end else if (icomp_s) begin
        dstreak_r <= '0;
      end else if ((state_r == IDLE) && !iREN) begin
        dstreak_r <= '0;
      end
    end
  end

  // Next-state decision: data first unless the fetch has been starved.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (dreq_s && !(iREN && (dstreak_r == DS_MAX))) begin
          next_s = DGNT;
        end else if (iREN) begin
          next_s = IGNT;
        end else begin
          next_s = IDLE;
        end
      end
      IGNT: begin
        // Abort and completion both return to IDLE; ERROR/FREE/BUSY hold.
        if (!iREN || (ramstate == ACCESS)) begin
          next_s = IDLE;
        end else begin
          next_s = IGNT;
        end
      end
      DGNT: begin
        if (!dreq_s || (ramstate == ACCESS)) begin
          next_s = IDLE;
        end else begin
          next_s = DGNT;
        end
      end
      default: next_s = IDLE;
    endcase
  end

  // RAM strobes from registered state only; waits fold in ramstate.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    iwait    = iREN   & ~((state_r == IGNT) && (ramstate == ACCESS));
    dwait    = dreq_s & ~((state_r == DGNT) && (ramstate == ACCESS));
    case (state_r)
      IGNT: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DGNT: begin
        ramaddr = daddr;
        if (dWEN) begin
          ramWEN   = 1'b1;
          ramstore = dstore;
        end else begin
          ramREN = 1'b1;
        end
      end
      default: begin
        ramREN = 1'b0;
        ramWEN = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter. Directed stimulus pushes each expected
// completion into a scoreboard queue; a monitor on the falling edge pops and
// compares whenever a requester's wait drops while it is requesting.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic        CLK;
  logic        nRST;
  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        memerr;

  typedef struct {
    logic        is_d;
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sco_q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DSTREAK(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .memerr(memerr)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic is_d, input logic we, input logic [31:0] addr,
                      input logic [31:0] data);
    exp_t e;
    e.is_d = is_d;
    e.we   = we;
    e.addr = addr;
    e.data = data;
    sco_q.push_back(e);
  endtask

  // Advance to just after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Settle point for directed checks, before the falling edge.
  task automatic probe();
    #3;
  endtask

  // Monitor: every completion must match the head of the scoreboard.
  logic icmp_m, dcmp_m;
  exp_t e_m;
  always @(negedge CLK) begin
    icmp_m = iREN && !iwait;
    dcmp_m = (dREN || dWEN) && !dwait;
    if (icmp_m || dcmp_m) begin
      if (sco_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_completion: got i=%0b d=%0b, expected none at %0t",
                 icmp_m, dcmp_m, $time);
      end else begin
        e_m = sco_q.pop_front();
        chk("completion_kind", {31'd0, dcmp_m}, {31'd0, e_m.is_d});
        chk("completion_addr", ramaddr, e_m.addr);
        if (e_m.we) begin
          chk("store_wen", {31'd0, ramWEN}, 32'd1);
          chk("store_data", ramstore, e_m.data);
        end else begin
          chk("read_ren", {31'd0, ramREN}, 32'd1);
          chk("read_data", dcmp_m ? dload : iload, e_m.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
    iaddr = 32'd0; daddr = 32'd0; dstore = 32'd0; ramload = 32'd0;
    ramstate = FREE;

    // Reset state: no strobes, waits follow raw requests.
    #2;
    iREN = 1'b1;
    #1;
    chk("rst_ramREN", {31'd0, ramREN}, 32'd0);
    chk("rst_ramWEN", {31'd0, ramWEN}, 32'd0);
    chk("rst_iwait", {31'd0, iwait}, 32'd1);
    chk("rst_memerr", {31'd0, memerr}, 32'd0);
    iREN = 1'b0;
    tick(); tick();
    nRST = 1'b1;
    tick();

    // Fetch with two BUSY cycles.
    iREN = 1'b1; iaddr = 32'h40;
    push(1'b0, 1'b0, 32'h40, 32'h3C010001);
    probe();
    chk("fetch_c0_ren", {31'd0, ramREN}, 32'd0);
    chk("fetch_c0_iwait", {31'd0, iwait}, 32'd1);
    tick(); ramstate = BUSY;
    probe();
    chk("fetch_c1_addr", ramaddr, 32'h40);
    chk("fetch_c1_ren", {31'd0, ramREN}, 32'd1);
    chk("fetch_c1_iwait", {31'd0, iwait}, 32'd1);
    tick();
    probe();
    chk("fetch_c2_iwait", {31'd0, iwait}, 32'd1);
    tick(); ramstate = ACCESS; ramload = 32'h3C010001;
    probe();
    chk("fetch_c3_iwait", {31'd0, iwait}, 32'd0);
    tick(); iREN = 1'b0; ramstate = FREE;
    probe();
    chk("fetch_bubble_ren", {31'd0, ramREN}, 32'd0);
    tick();

    // Contention: data first, bubble, then instruction.
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h44; daddr = 32'h100;
    ramstate = ACCESS; ramload = 32'hCAFE0001;
    push(1'b1, 1'b0, 32'h100, 32'hCAFE0001);
    push(1'b0, 1'b0, 32'h44, 32'hCAFE0001);
    tick();
    probe();
    chk("cont_c1_addr", ramaddr, 32'h100);
    chk("cont_c1_dwait", {31'd0, dwait}, 32'd0);
    chk("cont_c1_iwait", {31'd0, iwait}, 32'd1);
    tick(); dREN = 1'b0;
    probe();
    chk("cont_c2_ren", {31'd0, ramREN}, 32'd0);
    tick();
    probe();
    chk("cont_c3_addr", ramaddr, 32'h44);
    chk("cont_c3_iwait", {31'd0, iwait}, 32'd0);
    tick(); iREN = 1'b0; ramstate = FREE;
    tick();

    // Fairness: four data completions, one fetch, then data again.
    iREN = 1'b1; dREN = 1'b1; iaddr = 32'h80; daddr = 32'h300;
    ramstate = ACCESS; ramload = 32'h55AA55AA;
    for (int k = 0; k < 4; k++) push(1'b1, 1'b0, 32'h300, 32'h55AA55AA);
    push(1'b0, 1'b0, 32'h80, 32'h55AA55AA);
    push(1'b1, 1'b0, 32'h300, 32'h55AA55AA);
    for (int k = 0; k < 12; k++) tick();
    iREN = 1'b0; dREN = 1'b0; ramstate = FREE;
    tick();

    // Store: write strobe and data while BUSY, complete on ACCESS.
    dREN = 1'b1; dWEN = 1'b1; daddr = 32'h200; dstore = 32'hDEADBEEF;
    ramstate = BUSY;
    push(1'b1, 1'b1, 32'h200, 32'hDEADBEEF);
    tick();
    probe();
    chk("store_c1_wen", {31'd0, ramWEN}, 32'd1);
    chk("store_c1_ren", {31'd0, ramREN}, 32'd0);
    chk("store_c1_data", ramstore, 32'hDEADBEEF);
    chk("store_c1_dwait", {31'd0, dwait}, 32'd1);
    tick(); ramstate = ACCESS;
    probe();
    chk("store_c2_dwait", {31'd0, dwait}, 32'd0);
    tick(); dREN = 1'b0; dWEN = 1'b0; ramstate = FREE;
    tick();

    // Error then abort.
    dREN = 1'b1; daddr = 32'h400; ramstate = ERROR;
    tick();
    probe();
    chk("err_c1_dwait", {31'd0, dwait}, 32'd1);
    chk("err_c1_ren", {31'd0, ramREN}, 32'd1);
    tick();
    probe();
    chk("err_c2_memerr", {31'd0, memerr}, 32'd1);
    chk("err_c2_dwait", {31'd0, dwait}, 32'd1);
    chk("err_c2_addr", ramaddr, 32'h400);
    tick(); dREN = 1'b0; ramstate = FREE;
    tick();
    probe();
    chk("abort_ren", {31'd0, ramREN}, 32'd0);
    chk("abort_wen", {31'd0, ramWEN}, 32'd0);
    chk("abort_memerr", {31'd0, memerr}, 32'd1);
    tick();

    // Reset mid-DGNT with a fetch pending.
    dREN = 1'b1; iREN = 1'b1; daddr = 32'h500; iaddr = 32'h88; ramstate = BUSY;
    tick();
    probe();
    chk("midrst_pre_ren", {31'd0, ramREN}, 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("midrst_ren", {31'd0, ramREN}, 32'd0);
    chk("midrst_wen", {31'd0, ramWEN}, 32'd0);
    chk("midrst_iwait", {31'd0, iwait}, 32'd1);
    chk("midrst_dwait", {31'd0, dwait}, 32'd1);
    chk("midrst_memerr", {31'd0, memerr}, 32'd0);
    tick(); dREN = 1'b0; nRST = 1'b1;
    probe();
    chk("postrst_idle_ren", {31'd0, ramREN}, 32'd0);
    tick();
    probe();
    chk("postrst_igrant_addr", ramaddr, 32'h88);
    tick(); iREN = 1'b0; ramstate = FREE;
    tick(); tick();

    chk("scoreboard_empty", sco_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
